// File: rtl/seq_svm_classifier.sv
// Sequential one-vs-rest linear SVM: one class score per clock through a single shared MAC datapath.
// Result (ready + w_class) valid N_classes edges after reset release; held until the next reset.
module seq_svm_classifier #(
    parameter int N_features   = 11,
    parameter int feature_bits = 4,
    parameter int inputWidth   = 4,
    parameter int weightWidth  = 6,
    parameter int biasWidth    = 6,
    parameter int N_classes    = 6,
    parameter logic [N_classes*N_features*weightWidth-1:0] WEIGHTS = '0,
    parameter logic [N_classes*biasWidth-1:0]              BIASES  = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_features*feature_bits-1:0] in,
    output logic                               ready,
    output logic [$clog2(N_classes)-1:0]       w_class
);

    localparam int CNT_W = $clog2(N_classes);
    localparam int ACC_W = weightWidth + inputWidth + $clog2(N_features) + 2;

    typedef enum logic {RUN, DONE} state_t;

    state_t                            state;
    logic [CNT_W-1:0]                  cnt;
    logic [CNT_W-1:0]                  best_idx;
    logic [CNT_W-1:0]                  next_idx;
    logic [CNT_W-1:0]                  cls;
    logic signed [ACC_W-1:0]           best_score;
    logic signed [ACC_W-1:0]           score;
    logic signed [biasWidth-1:0]       bias_sel;
    logic signed [weightWidth-1:0]     w_sel;
    logic signed [inputWidth:0]        f_sel;
    logic [N_features*feature_bits-1:0] feat_reg;
    logic                              take;

    // Score of the class currently addressed by cnt; cls is clamped so DONE never indexes past the tables.
    always_comb begin
        cls      = (int'(cnt) < N_classes) ? cnt : '0;
        bias_sel = BIASES[int'(cls)*biasWidth +: biasWidth];
        w_sel    = '0;
        f_sel    = '0;
        score    = ACC_W'(bias_sel);
        for (int i = 0; i < N_features; i++) begin
            w_sel = WEIGHTS[(int'(cls)*N_features + i)*weightWidth +: weightWidth];
            f_sel = {1'b0, feat_reg[i*feature_bits +: inputWidth]};
            score = score + ACC_W'(w_sel) * ACC_W'(f_sel);
        end
        take     = (cnt == '0) || (score > best_score);
        next_idx = take ? cnt : best_idx;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= RUN;
            cnt        <= '0;
            best_score <= '0;
            best_idx   <= '0;
            ready      <= 1'b0;
            w_class    <= '0;
            feat_reg   <= in;
        end else begin
            case (state)
                RUN: begin
                    if (take) begin
                        best_score <= score;
                        best_idx   <= cnt;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(N_classes - 1)) begin
                        w_class <= next_idx;
                        ready   <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_svm_classifier.sv
// Directed bench: five parameterisations share clk/reset/in; expected winners queued per sample.
module tb_seq_svm_classifier;

    localparam int NF = 11;
    localparam int FB = 4;
    localparam int NC = 6;
    localparam int WW = 6;
    localparam int BW = 6;
    localparam int WT = NC*NF*WW;

    localparam logic [NC*BW-1:0] B2 = {6'd0, 6'd0, 6'd5, 6'd0, 6'd0, 6'd0};
    localparam logic [NC*BW-1:0] B3 = {6'd0, 6'd31, 6'd0, 6'd0, 6'd0, 6'd0};
    localparam logic [WT-1:0]    W3 = WT'(6'd31) << ((2*NF + 0)*WW);
    localparam logic [NC*BW-1:0] B4 = {6'h20, 6'd10, 6'h20, 6'h20, 6'd10, 6'h20};
    localparam logic [NC*BW-1:0] B5 = {6{6'h20}};
    localparam logic [WT-1:0]    W5 = {{(NF*WW){1'b1}}, {(WT-NF*WW){1'b0}}};

    typedef struct packed {
        logic [2:0] c0;
        logic [2:0] c2;
        logic [2:0] c3;
        logic [2:0] c4;
        logic [2:0] c5;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NF*FB-1:0] in_bus = '0;
    logic           r0, r2, r3, r4, r5;
    logic [2:0]     w0, w2, w3, w4, w5;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    seq_svm_classifier u0 (.clk(clk), .rst_n(rst), .in(in_bus), .ready(r0), .w_class(w0));
    seq_svm_classifier #(.BIASES(B2)) u2 (.clk(clk), .rst_n(rst), .in(in_bus), .ready(r2), .w_class(w2));
    seq_svm_classifier #(.WEIGHTS(W3), .BIASES(B3)) u3 (.clk(clk), .rst_n(rst), .in(in_bus), .ready(r3), .w_class(w3));
    seq_svm_classifier #(.BIASES(B4)) u4 (.clk(clk), .rst_n(rst), .in(in_bus), .ready(r4), .w_class(w4));
    seq_svm_classifier #(.WEIGHTS(W5), .BIASES(B5)) u5 (.clk(clk), .rst_n(rst), .in(in_bus), .ready(r5), .w_class(w5));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset(input logic [NF*FB-1:0] v);
        @(negedge clk);
        rst    = 1'b1;
        in_bus = v;
        @(negedge clk);
        rst    = 1'b0;
    endtask

    task automatic drive_sample(input logic [NF*FB-1:0] v, input exp_t e);
        do_reset(v);
        sb.push_back(e);
        check("reset_ready", 16'({r0, r2, r3, r4, r5}), 16'h0);
        check("reset_wclass", 16'({w0, w2, w3, w4, w5}), 16'h0);
    endtask

    // Exact latency: ready low for five edges, high on the sixth; then result must hold.
    task automatic wait_result(input string tag);
        exp_t       e;
        logic [14:0] held;
        logic [63:0] junk;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i < 6) begin
                check({tag, "_busy_ready"}, 16'({r0, r2, r3, r4, r5}), 16'h0);
                check({tag, "_busy_wclass"}, 16'({w0, w2, w3, w4, w5}), 16'h0);
            end
        end
        check({tag, "_ready"}, 16'({r0, r2, r3, r4, r5}), 16'h1f);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 16'(sb.size()), 16'h1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        check({tag, "_u0"}, 16'(w0), 16'(e.c0));
        check({tag, "_u2"}, 16'(w2), 16'(e.c2));
        check({tag, "_u3"}, 16'(w3), 16'(e.c3));
        check({tag, "_u4"}, 16'(w4), 16'(e.c4));
        check({tag, "_u5"}, 16'(w5), 16'(e.c5));
        held = {w0, w2, w3, w4, w5};
        for (int i = 0; i < 10; i++) begin
            junk   = {$urandom, $urandom};
            in_bus = junk[NF*FB-1:0];
            @(negedge clk);
            check({tag, "_hold_ready"}, 16'({r0, r2, r3, r4, r5}), 16'h1f);
            check({tag, "_hold_wclass"}, 16'({w0, w2, w3, w4, w5}), 16'(held));
        end
    endtask

    initial begin
        logic [NF*FB-1:0] v_zero;
        logic [NF*FB-1:0] v_f15;
        logic [NF*FB-1:0] v_f1;
        logic [NF*FB-1:0] v_rnd;
        logic [63:0]      tmp;
        logic [3:0]       f0;

        v_zero = '0;
        v_f15  = {{(NF*FB-4){1'b0}}, 4'd15};
        v_f1   = {{(NF*FB-4){1'b0}}, 4'd1};

        // All features zero: u3 score2=0 < score4=31; u5 all scores -32 tie.
        drive_sample(v_zero, '{c0: 3'd0, c2: 3'd3, c3: 3'd4, c4: 3'd1, c5: 3'd0});
        wait_result("zero");

        // feature0=15: u3 score2=465 > 31; u5 score5=-47.
        drive_sample(v_f15, '{c0: 3'd0, c2: 3'd3, c3: 3'd2, c4: 3'd1, c5: 3'd0});
        wait_result("f15");

        // feature0=1: u3 score2=31 ties score4=31, lower index wins; u5 score5=-33.
        drive_sample(v_f1, '{c0: 3'd0, c2: 3'd3, c3: 3'd2, c4: 3'd1, c5: 3'd0});
        wait_result("f1");

        for (int k = 0; k < 2; k++) begin
            tmp   = {$urandom, $urandom};
            v_rnd = tmp[NF*FB-1:0];
            f0    = v_rnd[3:0];
            drive_sample(v_rnd, '{c0: 3'd0, c2: 3'd3, c3: (f0 == 4'd0) ? 3'd4 : 3'd2, c4: 3'd1, c5: 3'd0});
            wait_result("rnd");
        end

        // Abort on the third edge with new features, then disturb in after release.
        do_reset(v_f15);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b1;
        in_bus = v_zero;
        @(negedge clk);
        check("abort_ready", 16'({r0, r2, r3, r4, r5}), 16'h0);
        check("abort_wclass", 16'({w0, w2, w3, w4, w5}), 16'h0);
        rst    = 1'b0;
        in_bus = v_f15;
        sb.push_back('{c0: 3'd0, c2: 3'd3, c3: 3'd4, c4: 3'd1, c5: 3'd0});
        wait_result("abort");

        check("sb_drained", 16'(sb.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
